// File: rtl/prei_gradient_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : prei_gradient_gen_if
// Purpose  : Bundles the control, pixel-read and gradient-stream signals of
//            the pre-intra gradient source.
// Ports    : (interface signals)
//   start        1          begin-LCU pulse into the generator
//   busy         1          generator is walking an LCU
//   done         1          one-cycle end-of-LCU pulse
//   rd_en        1          pixel row read request
//   rd_row       7          padded-buffer row of the request, 0..65
//   rd_col       7          leftmost padded-buffer column, 0..56
//   rd_data      10*PIXW    ten pixels returned one cycle after rd_en
//   gx, gy       PIXW+3     signed Sobel gradients
//   counterrun1  1          gx/gy valid
//   counterrun2  1          counterrun1 delayed one cycle
//   cnt          6          cycle within the 64-cycle block period
//   blockcnt     7          0 idle, 1..64 block, 65 drain
// Modports : master = generator side, slave = buffer / consumer side
// Revision : 1.0 - initial release
// ============================================================================
interface prei_gradient_gen_if #(
  parameter int PIXW = 8
);
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   rd_en;
  logic [6:0]             rd_row;
  logic [6:0]             rd_col;
  logic [10*PIXW-1:0]     rd_data;
  logic signed [PIXW+2:0] gx;
  logic signed [PIXW+2:0] gy;
  logic                   counterrun1;
  logic                   counterrun2;
  logic [5:0]             cnt;
  logic [6:0]             blockcnt;

  modport master (
    input  start, rd_data,
    output busy, done, rd_en, rd_row, rd_col, gx, gy,
           counterrun1, counterrun2, cnt, blockcnt
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_en, rd_row, rd_col, gx, gy,
           counterrun1, counterrun2, cnt, blockcnt
  );
endinterface
`default_nettype wire

// File: rtl/prei_gradient_gen.sv
`default_nettype none
// ============================================================================
// Module   : prei_gradient_gen
// Purpose  : Walks the 64 8x8 blocks of one 64x64 LCU in z-order, fetches
//            each block's 10x10 padded window row by row, and streams 16
//            3x3 Sobel gradients per block (4x4 subsampled grid) with the
//            counterrun1/counterrun2/cnt/blockcnt framing used by the DC /
//            planar decision stage.
// Ports    :
//   clk          in   1      clock
//   rst          in   1      synchronous active-high reset
//   bus          master modport of prei_gradient_gen_if
//                (start, rd_data in; busy, done, rd_en, rd_row, rd_col,
//                 gx, gy, counterrun1, counterrun2, cnt, blockcnt out)
// Timing   : every block period is 64 cycles:
//              cnt 0..9    row reads (data returns on cnt 1..10)
//              cnt 11..26  one gradient per cycle, counterrun1 high
//              cnt 12..27  counterrun2 high
//            64 block periods are followed by one 64-cycle drain period
//            (blockcnt 65) ending with the done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module prei_gradient_gen #(
  parameter int PIXW = 8
) (
  input wire logic            clk,
  input wire logic            rst,
  prei_gradient_gen_if.master bus
);

  localparam int         GW          = PIXW + 3;
  localparam logic [5:0] C_CNT_LAST  = 6'd63;
  localparam logic [6:0] C_BLK_LAST  = 7'd64;
  localparam logic [5:0] C_RD_LAST   = 6'd9;
  localparam logic [5:0] C_WR_FIRST  = 6'd1;
  localparam logic [5:0] C_WR_LAST   = 6'd10;
  localparam logic [5:0] C_GR_FIRST  = 6'd11;
  localparam logic [5:0] C_GR_LAST   = 6'd26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  state_t                 r_state;
  logic [5:0]             r_cnt;
  logic [6:0]             r_blockcnt;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_rd_en;
  logic [6:0]             r_rd_row;
  logic [6:0]             r_rd_col;
  logic signed [GW-1:0]   r_gx;
  logic signed [GW-1:0]   r_gy;
  logic                   r_cr1;
  logic                   r_cr2;

  // Pixel window: entry k holds window row k, pixel j at [j*PIXW +: PIXW].
  logic [10*PIXW-1:0]     r_win [10];

  // --------------------------------------------------------------------------
  // Next-state / next-output signals
  // --------------------------------------------------------------------------
  state_t                 w_state_nxt;
  logic [5:0]             w_cnt_nxt;
  logic [6:0]             w_blockcnt_nxt;
  logic                   w_run_nxt;
  logic [5:0]             w_b;
  logic [2:0]             w_bx;
  logic [2:0]             w_by;
  logic                   w_rd_en_nxt;
  logic [6:0]             w_rd_row_nxt;
  logic [6:0]             w_rd_col_nxt;
  logic                   w_cr1_nxt;
  logic                   w_done_nxt;
  logic                   w_busy_nxt;
  logic                   w_win_we;
  logic [3:0]             w_win_idx;
  logic [3:0]             w_gi;
  logic [3:0]             w_gr;
  logic [3:0]             w_gc;
  logic [10*PIXW-1:0]     w_row_m;
  logic [10*PIXW-1:0]     w_row_0;
  logic [10*PIXW-1:0]     w_row_p;
  logic signed [GW-1:0]   w_gx;
  logic signed [GW-1:0]   w_gy;

  // Zero-extended pixel `col` of a stored window row.
  function automatic logic signed [GW-1:0] f_pix(
    input logic [10*PIXW-1:0] row,
    input logic [3:0]         col
  );
    f_pix = signed'({3'b000, row[col*PIXW +: PIXW]});
  endfunction

  // --------------------------------------------------------------------------
  // Sequencer: next state, cnt and blockcnt
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_blockcnt_nxt = r_blockcnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt      = 6'd0;
        w_blockcnt_nxt = 7'd0;
        if (bus.start) begin
          w_state_nxt    = ST_RUN;
          w_blockcnt_nxt = 7'd1;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt + 6'd1;
        if (r_cnt == C_CNT_LAST) begin
          // Wrapping out of block 64 lands on 65, the drain period.
          w_blockcnt_nxt = r_blockcnt + 7'd1;
          if (r_blockcnt == C_BLK_LAST) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        w_cnt_nxt = r_cnt + 6'd1;
        if (r_cnt == C_CNT_LAST) begin
          w_state_nxt    = ST_IDLE;
          w_blockcnt_nxt = 7'd0;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_cnt_nxt      = 6'd0;
        w_blockcnt_nxt = 7'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode. Every output is registered, so it is decoded from the
  // next-cycle cnt/blockcnt and lines up with them once registered.
  // --------------------------------------------------------------------------
  always_comb begin
    w_run_nxt    = (w_state_nxt == ST_RUN);
    // z-order: x from even bits of the block index, y from odd bits.
    // blockcnt 64 wraps to index 63 in 6 bits, which is what we want.
    w_b          = w_blockcnt_nxt[5:0] - 6'd1;
    w_bx         = {w_b[4], w_b[2], w_b[0]};
    w_by         = {w_b[5], w_b[3], w_b[1]};
    w_rd_en_nxt  = w_run_nxt && (w_cnt_nxt <= C_RD_LAST);
    w_rd_row_nxt = {1'b0, w_by, 3'b000} + {1'b0, w_cnt_nxt};
    w_rd_col_nxt = {1'b0, w_bx, 3'b000};
    w_cr1_nxt    = w_run_nxt && (w_cnt_nxt >= C_GR_FIRST) && (w_cnt_nxt <= C_GR_LAST);
    w_done_nxt   = (w_state_nxt == ST_DRAIN) && (w_cnt_nxt == C_CNT_LAST);
    w_busy_nxt   = (w_state_nxt != ST_IDLE) && !w_done_nxt;
  end

  // --------------------------------------------------------------------------
  // Gradient datapath
  // Grid index i = cnt-11 (mod 16, i.e. cnt+5 in 4 bits); r = 2*(i>>2)+1,
  // c = 2*(i&3)+1. Only window rows/cols 0..8 are ever touched.
  // The gradient for cnt=11 is computed during cnt=10 from rows 0..2, which
  // are already stored; row 9 (captured on that same edge) is never used.
  // --------------------------------------------------------------------------
  always_comb begin
    w_gi    = w_cnt_nxt[3:0] + 4'd5;
    w_gr    = {1'b0, w_gi[3:2], 1'b1};
    w_gc    = {1'b0, w_gi[1:0], 1'b1};
    w_row_m = r_win[w_gr - 4'd1];
    w_row_0 = r_win[w_gr];
    w_row_p = r_win[w_gr + 4'd1];

    w_gx = (f_pix(w_row_m, w_gc + 4'd1)
            + (f_pix(w_row_0, w_gc + 4'd1) <<< 1)
            + f_pix(w_row_p, w_gc + 4'd1))
         - (f_pix(w_row_m, w_gc - 4'd1)
            + (f_pix(w_row_0, w_gc - 4'd1) <<< 1)
            + f_pix(w_row_p, w_gc - 4'd1));

    w_gy = (f_pix(w_row_p, w_gc - 4'd1)
            + (f_pix(w_row_p, w_gc) <<< 1)
            + f_pix(w_row_p, w_gc + 4'd1))
         - (f_pix(w_row_m, w_gc - 4'd1)
            + (f_pix(w_row_m, w_gc) <<< 1)
            + f_pix(w_row_m, w_gc + 4'd1));
  end

  // --------------------------------------------------------------------------
  // Window capture: the row requested at cnt=k returns during cnt=k+1.
  // Held off during reset so in-flight read data is dropped.
  // --------------------------------------------------------------------------
  assign w_win_we  = !rst && (r_state == ST_RUN)
                     && (r_cnt >= C_WR_FIRST) && (r_cnt <= C_WR_LAST);
  assign w_win_idx = r_cnt[3:0] - 4'd1;

  always_ff @(posedge clk) begin
    if (w_win_we) begin
      r_win[w_win_idx] <= bus.rd_data;
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 6'd0;
      r_blockcnt <= 7'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_row   <= 7'd0;
      r_rd_col   <= 7'd0;
      r_gx       <= '0;
      r_gy       <= '0;
      r_cr1      <= 1'b0;
      r_cr2      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_blockcnt <= w_blockcnt_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_cr1      <= w_cr1_nxt;
      r_cr2      <= r_cr1;
      // Addresses only move when a read is issued.
      if (w_rd_en_nxt) begin
        r_rd_row <= w_rd_row_nxt;
        r_rd_col <= w_rd_col_nxt;
      end
      // Gradients hold their last value between bursts.
      if (w_cr1_nxt) begin
        r_gx <= w_gx;
        r_gy <= w_gy;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Port drive
  // --------------------------------------------------------------------------
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.rd_en       = r_rd_en;
  assign bus.rd_row      = r_rd_row;
  assign bus.rd_col      = r_rd_col;
  assign bus.gx          = r_gx;
  assign bus.gy          = r_gy;
  assign bus.counterrun1 = r_cr1;
  assign bus.counterrun2 = r_cr2;
  assign bus.cnt         = r_cnt;
  assign bus.blockcnt    = r_blockcnt;

endmodule
`default_nettype wire
